// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg: state encoding, frame-length helper and default address map for spi_regfile_periph
package spi_regfile_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, CMD = 3'd1, WDATA = 3'd2, RDATA = 3'd3, COMMIT = 3'd4} state_e;
  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_PWM_DUTY  = 4;
  function automatic int frame_len(input int addr_w, input int data_w);
`ifdef SPI_REGFILE_PARITY_EN
    return 2 + addr_w + data_w;
`else
    return 1 + addr_w + data_w;
`endif
  endfunction
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: two-flop synchroniser plus history flop; resets to the pin's idle level
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic sync_o,
  output logic hist_o
);
  logic s1_q, s2_q, h_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1_q, s2_q, h_q} <= {3{RST_VAL}};
    else {s1_q, s2_q, h_q} <= {pin_i, s1_q, s2_q};
  assign sync_o = s2_q;
  assign hist_o = h_q;
endmodule

// File: rtl/spi_regfile_periph.sv
// spi_regfile_periph: oversampled SPI peripheral with read/write register bank.
// Define SPI_REGFILE_PARITY_EN to append a trailing even-parity bit that gates writes.
module spi_regfile_periph
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter bit CPOL     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic                         wr_pulse,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);
  localparam int FRAME = frame_len(ADDR_W, DATA_W);
  localparam int HDR   = 1 + ADDR_W;
  localparam int CW    = $clog2(FRAME + 2);
  logic sclk_s, sclk_h, ncs_s, ncs_h, copi_s, copi_h;
  spi_pin_sync #(.RST_VAL(CPOL)) u_sclk (.clk(clk), .rst_n(rst_n), .pin_i(sclk), .sync_o(sclk_s), .hist_o(sclk_h));
  spi_pin_sync #(.RST_VAL(1'b1)) u_ncs  (.clk(clk), .rst_n(rst_n), .pin_i(ncs),  .sync_o(ncs_s),  .hist_o(ncs_h));
  spi_pin_sync #(.RST_VAL(1'b0)) u_copi (.clk(clk), .rst_n(rst_n), .pin_i(copi), .sync_o(copi_s), .hist_o(copi_h));
  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d, cnt_inc;
  logic [FRAME-1:0]             shift_q, shift_d, shift_in;
  logic                         rw_q, rw_d;
  logic [ADDR_W-1:0]            addr_q, addr_d, hdr_addr, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]            tx_q, tx_d, wdata;
  logic [NUM_REGS*DATA_W-1:0]   bank_q, bank_d;
  logic                         wr_pulse_q, wr_pulse_d, frame_err_q, frame_err_d;
  logic                         sclk_rise, sclk_fall, sclk_act, sclk_inact, ncs_fall, ncs_rise;
  logic                         len_ok, addr_ok, hdr_addr_ok, par_ok, unused_sig;
  assign sclk_rise   = sclk_s & ~sclk_h;
  assign sclk_fall   = ~sclk_s & sclk_h;
  assign sclk_act    = CPOL ? sclk_fall : sclk_rise;
  assign sclk_inact  = CPOL ? sclk_rise : sclk_fall;
  assign ncs_fall    = ncs_h & ~ncs_s;
  assign ncs_rise    = ~ncs_h & ncs_s;
  assign cnt_inc     = (cnt_q == CW'(FRAME + 1)) ? cnt_q : cnt_q + 1'b1;
  assign shift_in    = {shift_q[FRAME-2:0], copi_s};
  assign hdr_addr    = shift_in[ADDR_W-1:0];
  assign hdr_addr_ok = int'(hdr_addr) < NUM_REGS;
  assign addr_ok     = int'(addr_q) < NUM_REGS;
  assign len_ok      = cnt_q == CW'(FRAME);
`ifdef SPI_REGFILE_PARITY_EN
  assign wdata       = shift_q[DATA_W:1];
  assign par_ok      = ~^shift_q;
  assign unused_sig  = copi_h;
`else
  assign wdata       = shift_q[DATA_W-1:0];
  assign par_ok      = 1'b1;
  assign unused_sig  = ^{copi_h, shift_q[FRAME-1]};
`endif
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; shift_d = shift_q; rw_d = rw_q; addr_d = addr_q;
    tx_d = tx_q; bank_d = bank_q; wr_addr_d = wr_addr_q; wr_pulse_d = 1'b0; frame_err_d = 1'b0;
    if (state_q == COMMIT) begin
      state_d = IDLE;
      if (len_ok && !rw_q && addr_ok && par_ok) begin
        bank_d[int'(addr_q)*DATA_W +: DATA_W] = wdata;
        wr_pulse_d = 1'b1;
        wr_addr_d = addr_q;
      end else frame_err_d = !(len_ok && rw_q);
    end else if (state_q == IDLE) begin
      if (ncs_fall) begin
        state_d = CMD; cnt_d = '0; shift_d = '0;
      end
    end else if (ncs_rise) state_d = COMMIT;
    else if (sclk_act) begin
      shift_d = shift_in; cnt_d = cnt_inc;
      if (state_q == CMD && cnt_inc == CW'(HDR)) begin
        rw_d = shift_in[HDR-1]; addr_d = hdr_addr;
        state_d = shift_in[HDR-1] ? RDATA : WDATA;
        tx_d = hdr_addr_ok ? bank_q[int'(hdr_addr)*DATA_W +: DATA_W] : '0;
      end
    // MSB is already on cipo for the first data bit, so the first trailing edge must not shift
    end else if (sclk_inact && state_q == RDATA && cnt_q != CW'(HDR)) tx_d = tx_q << 1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE; cnt_q <= '0; shift_q <= '0; rw_q <= 1'b0; addr_q <= '0; tx_q <= '0;
      bank_q <= '0; wr_addr_q <= '0; wr_pulse_q <= 1'b0; frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; shift_q <= shift_d; rw_q <= rw_d; addr_q <= addr_d; tx_q <= tx_d;
      bank_q <= bank_d; wr_addr_q <= wr_addr_d; wr_pulse_q <= wr_pulse_d; frame_err_q <= frame_err_d;
    end
  assign cipo      = (state_q == RDATA) & tx_q[DATA_W-1];
  assign reg_out   = bank_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;
endmodule
